// File: rtl/nx_stream_pkg.sv
// nx_stream_pkg: shared widths, lane keep patterns and packer state encoding
package nx_stream_pkg;

    localparam int MSG_WIDTH = 32;
    localparam int CTRL_BIT  = 31;

    localparam logic [7:0] KEEP_FULL = 8'hFF;
    localparam logic [7:0] KEEP_HALF = 8'h0F;

    typedef enum logic [1:0] {
        EMPTY,
        HALF,
        FULL
    } pack_state_t;

endpackage

// File: rtl/nx_stream_arbiter.sv
// nx_stream_arbiter: two-input fixed-priority valid/ready arbiter, input A wins
module nx_stream_arbiter #(
    parameter int DW = 31
) (
    input  logic          i_a_valid,
    input  logic [DW-1:0] i_a_data,
    input  logic          i_b_valid,
    input  logic [DW-1:0] i_b_data,
    input  logic          i_ready,
    output logic          o_a_ready,
    output logic          o_b_ready,
    output logic          o_valid,
    output logic          o_sel_a,
    output logic [DW-1:0] o_data
);

    // B is only offered a slot when A is not asking for it
    assign o_a_ready = i_ready;
    assign o_b_ready = i_ready && !i_a_valid;
    assign o_valid   = i_ready && (i_a_valid || i_b_valid);
    assign o_sel_a   = i_a_valid;
    assign o_data    = i_a_valid ? i_a_data : i_b_data;

endmodule

// File: rtl/nx_axi_ob_packer.sv
// nx_axi_ob_packer: merges control/core messages into 64-bit AXI4-stream beats, two 32-bit words per beat
module nx_axi_ob_packer
    import nx_stream_pkg::*;
#(
    parameter int AXI4_DATA_WIDTH = 64,
    parameter int AXI4_STRB_WIDTH = AXI4_DATA_WIDTH / 8,
    parameter int AXI4_ID_WIDTH   = 1,
    parameter int FLUSH_CYCLES    = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [30:0]                ctrl_data_i,
    input  logic                       ctrl_valid_i,
    output logic                       ctrl_ready_o,
    input  logic [30:0]                core_data_i,
    input  logic                       core_valid_i,
    output logic                       core_ready_o,
    output logic [AXI4_DATA_WIDTH-1:0] outbound_tdata,
    output logic [AXI4_STRB_WIDTH-1:0] outbound_tkeep,
    output logic [AXI4_STRB_WIDTH-1:0] outbound_tstrb,
    output logic [AXI4_ID_WIDTH-1:0]   outbound_tid,
    output logic                       outbound_tlast,
    output logic                       outbound_tvalid,
    input  logic                       outbound_tready,
    output logic                       idle_o
);

    localparam int TW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(FLUSH_CYCLES - 1);

    pack_state_t                r_state, w_state_n;
    logic [TW-1:0]              r_timer, w_timer_n;
    logic [MSG_WIDTH-1:0]       r_lane0, w_lane0_n;
    logic [AXI4_DATA_WIDTH-1:0] r_tdata, w_tdata_n;
    logic [AXI4_STRB_WIDTH-1:0] r_tkeep, w_tkeep_n;
    logic                       r_tvalid, w_tvalid_n;

    logic                       w_can_accept;
    logic                       w_accept;
    logic                       w_sel_ctrl;
    logic [CTRL_BIT-1:0]        w_msg;
    logic [MSG_WIDTH-1:0]       w_word;

    // A full beat blocks intake until downstream takes it in the same cycle
    assign w_can_accept = (r_state != FULL) || outbound_tready;

    nx_stream_arbiter #(.DW(CTRL_BIT)) u_arb (
        .i_a_valid (ctrl_valid_i),
        .i_a_data  (ctrl_data_i),
        .i_b_valid (core_valid_i),
        .i_b_data  (core_data_i),
        .i_ready   (w_can_accept),
        .o_a_ready (ctrl_ready_o),
        .o_b_ready (core_ready_o),
        .o_valid   (w_accept),
        .o_sel_a   (w_sel_ctrl),
        .o_data    (w_msg)
    );

    assign w_word = {w_sel_ctrl, w_msg};

    // State register and registered AXI outputs; reset drops any pending lane
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= EMPTY;
            r_timer  <= '0;
            r_lane0  <= '0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tvalid <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_timer  <= w_timer_n;
            r_lane0  <= w_lane0_n;
            r_tdata  <= w_tdata_n;
            r_tkeep  <= w_tkeep_n;
            r_tvalid <= w_tvalid_n;
        end
    end

    // Next state: park a lone word in lane 0, pair it or time it out into a half beat
    always_comb begin
        w_state_n  = r_state;
        w_timer_n  = r_timer;
        w_lane0_n  = r_lane0;
        w_tdata_n  = r_tdata;
        w_tkeep_n  = r_tkeep;
        w_tvalid_n = r_tvalid;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_lane0_n = w_word;
                    w_timer_n = '0;
                    w_state_n = HALF;
                end
            end
            HALF: begin
                if (w_accept) begin
                    w_tdata_n  = {w_word, r_lane0};
                    w_tkeep_n  = KEEP_FULL;
                    w_tvalid_n = 1'b1;
                    w_state_n  = FULL;
                end else if (flush_i || r_timer == TIMER_LAST) begin
                    w_tdata_n  = {{MSG_WIDTH{1'b0}}, r_lane0};
                    w_tkeep_n  = KEEP_HALF;
                    w_tvalid_n = 1'b1;
                    w_state_n  = FULL;
                end else begin
                    w_timer_n = r_timer + 1'b1;
                end
            end
            FULL: begin
                if (outbound_tready) begin
                    w_tvalid_n = 1'b0;
                    w_timer_n  = '0;
                    w_lane0_n  = w_accept ? w_word : r_lane0;
                    w_state_n  = w_accept ? HALF : EMPTY;
                end
            end
            default: w_state_n = EMPTY;
        endcase
    end

    assign outbound_tdata  = r_tdata;
    assign outbound_tkeep  = r_tkeep;
    assign outbound_tstrb  = r_tkeep;
    assign outbound_tid    = '0;
    assign outbound_tlast  = r_tvalid;
    assign outbound_tvalid = r_tvalid;
    assign idle_o          = (r_state == EMPTY);

endmodule

// File: tb/tb_nx_axi_ob_packer.sv
// tb_nx_axi_ob_packer: directed and randomized check of the outbound packer against a word-level model
module tb_nx_axi_ob_packer;

    localparam int F = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [30:0] ctrl_data_i = '0;
    logic        ctrl_valid_i = 1'b0;
    logic        ctrl_ready_o;
    logic [30:0] core_data_i = '0;
    logic        core_valid_i = 1'b0;
    logic        core_ready_o;
    logic [63:0] outbound_tdata;
    logic [7:0]  outbound_tkeep;
    logic [7:0]  outbound_tstrb;
    logic [0:0]  outbound_tid;
    logic        outbound_tlast;
    logic        outbound_tvalid;
    logic        outbound_tready = 1'b0;
    logic        idle_o;

    int n_vec = 0;
    int n_err = 0;

    // Word-level model: a presented beat plus at most one word waiting for a partner
    bit          m_bv;
    logic [63:0] m_bd;
    logic [7:0]  m_bk;
    bit          m_hp;
    logic [31:0] m_p;
    int          m_wait;

    nx_axi_ob_packer #(.FLUSH_CYCLES(F)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .ctrl_data_i     (ctrl_data_i),
        .ctrl_valid_i    (ctrl_valid_i),
        .ctrl_ready_o    (ctrl_ready_o),
        .core_data_i     (core_data_i),
        .core_valid_i    (core_valid_i),
        .core_ready_o    (core_ready_o),
        .outbound_tdata  (outbound_tdata),
        .outbound_tkeep  (outbound_tkeep),
        .outbound_tstrb  (outbound_tstrb),
        .outbound_tid    (outbound_tid),
        .outbound_tlast  (outbound_tlast),
        .outbound_tvalid (outbound_tvalid),
        .outbound_tready (outbound_tready),
        .idle_o          (idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_bv = 1'b0;
        m_bd = '0;
        m_bk = '0;
        m_hp = 1'b0;
        m_p = '0;
        m_wait = 0;
    endtask

    task automatic compare();
        bit can;
        can = !m_bv || outbound_tready;
        chk("ctrl_ready", 64'(ctrl_ready_o), 64'(can));
        chk("core_ready", 64'(core_ready_o), 64'(can && !ctrl_valid_i));
        chk("tvalid", 64'(outbound_tvalid), 64'(m_bv));
        chk("tlast", 64'(outbound_tlast), 64'(m_bv));
        chk("tid", 64'(outbound_tid), 64'd0);
        chk("idle", 64'(idle_o), 64'(!m_bv && !m_hp));
        if (m_bv) begin
            chk("tdata", outbound_tdata, m_bd);
            chk("tkeep", 64'(outbound_tkeep), 64'(m_bk));
            chk("tstrb", 64'(outbound_tstrb), 64'(m_bk));
        end
    endtask

    task automatic model_step();
        bit can;
        bit acc;
        logic [31:0] w;
        can = !m_bv || outbound_tready;
        acc = can && (ctrl_valid_i || core_valid_i);
        w = ctrl_valid_i ? {1'b1, ctrl_data_i} : {1'b0, core_data_i};
        if (m_bv && outbound_tready) m_bv = 1'b0;
        if (acc && m_hp) begin
            m_bd = {w, m_p};
            m_bk = 8'hFF;
            m_bv = 1'b1;
            m_hp = 1'b0;
        end else if (acc) begin
            m_p = w;
            m_hp = 1'b1;
            m_wait = 0;
        end else if (m_hp) begin
            if (flush_i || m_wait == F - 1) begin
                m_bd = {32'h0, m_p};
                m_bk = 8'h0F;
                m_bv = 1'b1;
                m_hp = 1'b0;
            end else begin
                m_wait++;
            end
        end
    endtask

    task automatic step(input bit cv, input logic [30:0] cd, input bit kv, input logic [30:0] kd,
                        input bit fl, input bit tr);
        ctrl_valid_i = cv;
        ctrl_data_i = cd;
        core_valid_i = kv;
        core_data_i = kd;
        flush_i = fl;
        outbound_tready = tr;
        #1;
        compare();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    task automatic idle(input bit tr);
        step(1'b0, '0, 1'b0, '0, 1'b0, tr);
    endtask

    initial begin
        m_reset();
        #3;
        chk("rst_tvalid", 64'(outbound_tvalid), 64'd0);
        chk("rst_tdata", outbound_tdata, 64'd0);
        chk("rst_tkeep", 64'(outbound_tkeep), 64'd0);
        chk("rst_tstrb", 64'(outbound_tstrb), 64'd0);
        chk("rst_tlast", 64'(outbound_tlast), 64'd0);
        chk("rst_tid", 64'(outbound_tid), 64'd0);
        chk("rst_idle", 64'(idle_o), 64'd1);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Two core words back to back form one full beat
        step(1'b0, '0, 1'b1, 31'h11, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 31'h22, 1'b0, 1'b1);
        chk("pair_tdata", outbound_tdata, 64'h0000_0022_0000_0011);
        chk("pair_tkeep", 64'(outbound_tkeep), 64'hFF);
        chk("pair_tlast", 64'(outbound_tlast), 64'd1);
        idle(1'b1);

        // Lone control word times out into a half beat after F cycles
        step(1'b1, 31'h5, 1'b0, '0, 1'b0, 1'b1);
        repeat (F - 1) idle(1'b1);
        chk("lone_not_yet", 64'(outbound_tvalid), 64'd0);
        idle(1'b1);
        chk("lone_tvalid", 64'(outbound_tvalid), 64'd1);
        chk("lone_tdata", outbound_tdata, 64'h0000_0000_8000_0005);
        chk("lone_tkeep", 64'(outbound_tkeep), 64'h0F);
        idle(1'b1);

        // Control beats core when both are valid
        ctrl_valid_i = 1'b1;
        ctrl_data_i = 31'h1;
        core_valid_i = 1'b1;
        core_data_i = 31'h2;
        #1;
        chk("arb_core_ready", 64'(core_ready_o), 64'd0);
        chk("arb_ctrl_ready", 64'(ctrl_ready_o), 64'd1);
        step(1'b1, 31'h1, 1'b1, 31'h2, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 31'h2, 1'b0, 1'b1);
        chk("arb_tdata", outbound_tdata, 64'h0000_0002_8000_0001);
        chk("arb_tkeep", 64'(outbound_tkeep), 64'hFF);
        idle(1'b1);

        // Backpressure holds the beat; release with a new word starts the next beat
        step(1'b0, '0, 1'b1, 31'h21, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 31'h22, 1'b0, 1'b0);
        repeat (5) step(1'b0, '0, 1'b1, 31'h44, 1'b0, 1'b0);
        chk("hold_tdata", outbound_tdata, 64'h0000_0022_0000_0021);
        chk("hold_tvalid", 64'(outbound_tvalid), 64'd1);
        step(1'b0, '0, 1'b1, 31'h44, 1'b0, 1'b1);
        chk("retire_tvalid", 64'(outbound_tvalid), 64'd0);
        chk("retire_idle", 64'(idle_o), 64'd0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        chk("next_tdata", outbound_tdata, 64'h0000_0000_0000_0044);
        chk("next_tkeep", 64'(outbound_tkeep), 64'h0F);
        idle(1'b1);

        // Flush coinciding with the second word still yields a full beat
        step(1'b0, '0, 1'b1, 31'h51, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 31'h52, 1'b1, 1'b1);
        chk("flush_acc_tkeep", 64'(outbound_tkeep), 64'hFF);
        chk("flush_acc_tdata", outbound_tdata, 64'h0000_0052_0000_0051);
        idle(1'b1);

        // Reset while a lone word is pending discards it
        step(1'b0, '0, 1'b1, 31'h33, 1'b0, 1'b1);
        rst_i = 1'b1;
        #1;
        chk("rst_half_tvalid", 64'(outbound_tvalid), 64'd0);
        chk("rst_half_idle", 64'(idle_o), 64'd1);
        m_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (F + 4) idle(1'b1);
        chk("rst_half_gone", 64'(outbound_tvalid), 64'd0);

        // Reset while a full beat is presented clears the outputs at once
        step(1'b0, '0, 1'b1, 31'h61, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 31'h62, 1'b0, 1'b0);
        rst_i = 1'b1;
        #1;
        chk("rst_full_tvalid", 64'(outbound_tvalid), 64'd0);
        chk("rst_full_tkeep", 64'(outbound_tkeep), 64'd0);
        chk("rst_full_tdata", outbound_tdata, 64'd0);
        m_reset();
        @(negedge clk_i);
        rst_i = 1'b0;

        // Random traffic: dense phase, then sparse phase that exercises timeouts
        for (int ph = 0; ph < 2; ph++) begin
            repeat (2500) begin
                int lim;
                lim = (ph == 0) ? 3 : 30;
                step($urandom_range(0, lim) == 0, 31'($urandom),
                     $urandom_range(0, lim) == 0, 31'($urandom),
                     $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
